// File: rtl/mips_data_mem_arbiter_if.sv
// mips_data_mem_arbiter_if
//   Bundles the three buses around the data-memory arbiter:
//     cpu_*  : CPU data-side requester (address, write, read, writedata in;
//              readdata, waitrequest out of the arbiter)
//     dbg_*  : debug/loader requester, same shape as cpu_*
//     mem_*  : single data-memory port (address, strobes, writedata out of
//              the arbiter; readdata back into it, valid the cycle after
//              mem_read)
//     busy   : arbiter is waiting on a read return
//   Modports:
//     master : the environment side (requesters + memory)
//     slave  : the arbiter itself
interface mips_data_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_write;
  logic              cpu_read;
  logic [DATA_W-1:0] cpu_writedata;
  logic [DATA_W-1:0] cpu_readdata;
  logic              cpu_waitrequest;

  logic [ADDR_W-1:0] dbg_address;
  logic              dbg_write;
  logic              dbg_read;
  logic [DATA_W-1:0] dbg_writedata;
  logic [DATA_W-1:0] dbg_readdata;
  logic              dbg_waitrequest;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;

  logic              busy;

  modport master (
    output cpu_address, cpu_write, cpu_read, cpu_writedata,
    input  cpu_readdata, cpu_waitrequest,
    output dbg_address, dbg_write, dbg_read, dbg_writedata,
    input  dbg_readdata, dbg_waitrequest,
    input  mem_address, mem_write, mem_read, mem_writedata,
    output mem_readdata,
    input  busy
  );

  modport slave (
    input  cpu_address, cpu_write, cpu_read, cpu_writedata,
    output cpu_readdata, cpu_waitrequest,
    input  dbg_address, dbg_write, dbg_read, dbg_writedata,
    output dbg_readdata, dbg_waitrequest,
    output mem_address, mem_write, mem_read, mem_writedata,
    input  mem_readdata,
    output busy
  );
endinterface

// File: rtl/mips_data_mem_arbiter.sv
// mips_data_mem_arbiter
//   Shares one data-memory port between the CPU data interface and a
//   debug/loader port. Writes are granted and committed in a single cycle;
//   reads take a grant cycle plus a READ_WAIT cycle in which the memory's
//   registered read data is steered back to the owning port. A losing or
//   stalled requester sees waitrequest = 1 and must hold its request.
//
//   Ports:
//     clk        : rising-edge clock
//     reset      : synchronous, active-high
//     clk_enable : 0 freezes state and suppresses memory strobes
//     bus        : mips_data_mem_arbiter_if.slave (cpu_*, dbg_*, mem_*, busy)
//
//   Build option:
//     MEM_ARB_ROUND_ROBIN_EN defined   -> contention goes to the port that
//                                         did not win the previous grant
//     MEM_ARB_ROUND_ROBIN_EN undefined -> CPU always wins contention
module mips_data_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                     clk,
  input logic                     reset,
  input logic                     clk_enable,
  mips_data_mem_arbiter_if.slave  bus
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] READ_WAIT = 1'b1;

  logic [0:0] state;
  logic       last_grant;   // 0 = CPU, 1 = dbg
  logic       owner_dbg;    // owner of the read in flight

  logic              req_cpu;
  logic              req_dbg;
  logic              any_req;
  logic              contention_dbg;
  logic              grant_dbg;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_address;
  logic [DATA_W-1:0] sel_writedata;

  assign req_cpu = bus.cpu_write | bus.cpu_read;
  assign req_dbg = bus.dbg_write | bus.dbg_read;
  assign any_req = req_cpu | req_dbg;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign contention_dbg = ~last_grant;
`else
  // last_grant is still tracked so behaviour of the register is identical
  // in both builds; fixed priority simply never consults it.
  assign contention_dbg = 1'b0 & last_grant;
`endif

  // A lone requester always wins; contention is resolved by the build option.
  assign grant_dbg     = req_dbg & (~req_cpu | contention_dbg);
  assign sel_write     = grant_dbg ? bus.dbg_write     : bus.cpu_write;
  assign sel_address   = grant_dbg ? bus.dbg_address   : bus.cpu_address;
  assign sel_writedata = grant_dbg ? bus.dbg_writedata : bus.cpu_writedata;

  always_comb begin
    bus.mem_address     = '0;
    bus.mem_writedata   = '0;
    bus.mem_write       = 1'b0;
    bus.mem_read        = 1'b0;
    bus.cpu_readdata    = '0;
    bus.dbg_readdata    = '0;
    // Any requester not explicitly completed this cycle is stalled; a port
    // with no request sees 0.
    bus.cpu_waitrequest = req_cpu;
    bus.dbg_waitrequest = req_dbg;
    bus.busy            = 1'b0;

    if (!reset) begin
      if (state == READ_WAIT) begin
        bus.busy = 1'b1;
        // Memory output is gated by clk_enable too, so the data stays valid
        // while frozen; only the completion handshake waits for re-enable.
        if (owner_dbg) begin
          bus.dbg_readdata    = bus.mem_readdata;
          bus.dbg_waitrequest = ~clk_enable;
        end else begin
          bus.cpu_readdata    = bus.mem_readdata;
          bus.cpu_waitrequest = ~clk_enable;
        end
      end else if (any_req) begin
        bus.mem_address   = sel_address;
        bus.mem_writedata = sel_writedata;
        if (clk_enable) begin
          // Write has precedence over a simultaneous read on the same port.
          if (sel_write) begin
            bus.mem_write = 1'b1;
            if (grant_dbg) bus.dbg_waitrequest = 1'b0;
            else           bus.cpu_waitrequest = 1'b0;
          end else begin
            bus.mem_read = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner_dbg  <= 1'b0;
    end else if (clk_enable) begin
      case (state)
        IDLE: begin
          if (any_req) begin
            last_grant <= grant_dbg;
            if (!sel_write) begin
              state     <= READ_WAIT;
              owner_dbg <= grant_dbg;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
